ioexp_multiport_ctrl: RTL and testbench
=======================================

// Module: ioexp_multiport_ctrl
// PURPOSE
//  Parametrised SMBus IO-expander register bank, NPORT x 8-bit ports (PCA9506-style map), driven by the
//  byte-level offset/data interface of the SMBus slave. Adds the following over the 2-port design:
//   - polarity inversion
//   - per-bit interrupt mask
//   - per-port pending latch, cleared on read
//   - reset-priming FSM that suppresses spurious interrupts after reset
// PARAMETERS
//  NPORT      2          number of 8-bit ports, 1..8
//  OUT_RST    {NPORT{8'hFF}}  output register reset value
//  CFG_RST    {NPORT{8'hFF}}  config reset value (1=input, 0=output)
//  MASK_RST   {NPORT{8'hFF}}  interrupt mask reset value (1=masked)
//  FILTER_CYC 16         stable cycles required by input filter (IOEXP_INPUT_FILTER_EN only), 1..65535
// PORTS
//  iClk      in   1        system clock
//  nrst      in   1        reset, asynchronous, active-low
//  iWrEn     in   1        1-cycle write strobe from SMBus slave
//  iRdEn     in   1        1-cycle read strobe (byte fetched at iOffset)
//  iOffset   in   8        register offset
//  iWrData   in   8        write byte
//  oRdData   out  8        read byte, combinational from iOffset
//  iIntEn    in   1        global interrupt enable; 0 forces oInt_n=1, pending still latches
//  iPins     in   NPORT*8  raw asynchronous pin inputs; port p = [8p+7:8p]
//  oOut      out  NPORT*8  output register value
//  oOe       out  NPORT*8  pin output enable = ~CFG
//  oInt_n    out  1        registered interrupt, active-low
//  oPending  out  NPORT    per-port pending flag (any bit)
// BEHAVIOUR
//  Register map, groups at stride 8, p = 0..NPORT-1:
//   - IN 0x00+p (RO)
//   - OUT 0x08+p
//   - POL 0x10+p
//   - CFG 0x18+p
//   - MSK 0x20+p
//  Map rules:
//   - Unmapped offsets, or p >= NPORT: read 8'hFF, writes ignored.
//   - Writes to IN are ignored.
//  Reset values:
//   - OUT=OUT_RST, CFG=CFG_RST, MSK=MASK_RST, POL=0, pending=0, snapshot=0.
//   - oInt_n=1; oOut=OUT_RST; oOe=~CFG_RST; oPending=0.
//   - FSM enters PRIME.
//  Input path: iPins -> 2-flop sync -> (optional filter) -> XOR POL = val.
//   - IN read data = val (live).
//  Change detect:
//   - diff[b] = val[b] != snap[b].
//   - If diff[b] and FSM=RUN: pend[b] <= 1, one cycle after diff.
//   - pend is sticky until cleared.
//  Read-to-clear: iRdEn at IN p (p < NPORT) -> snap[p] <= val[p] and pend[p] <= 0 in the same edge.
//   - Clear has priority over set on that edge.
//   - A change on the following cycle re-sets pend.
//  Interrupt: oInt_n <= ~(iIntEn & |(pend & ~MSK)), registered.
//   - Pin-to-oInt_n latency is 4 iClk without the filter.
//   - Masking a pending bit deasserts oInt_n on the next edge; pend stays set.
//   - Unmasking a still-pending bit reasserts oInt_n on the next edge.
//   - oPending[p] = |pend[p] and is unaffected by MSK.
//  POL write: changes val, which is a change and sets pend if snap differs. This is intended.
//  FSM:
//   - PRIME: 2-bit counter runs 3 cycles; snap <= val every cycle; pend held 0. Then -> RUN.
//   - RUN: normal operation. Left only by nrst.
//  Simultaneous iWrEn and iRdEn: both act. The write never targets IN, so there is no conflict.
//  Reset asserted mid-operation: every state returns to its reset value immediately. No partial-write retention.
// CONFIGURATION
//  IOEXP_INPUT_FILTER_EN defined:
//   - Per-bit 16-bit stability counter after the synchroniser.
//   - Filtered bit updates only after the raw bit has held a new level for FILTER_CYC consecutive cycles.
//   - The counter restarts on any toggle.
//   - Latency is 4+FILTER_CYC cycles.
//   - PRIME is extended until every counter has expired once, so the filtered value is seeded from the pins.
//  IOEXP_INPUT_FILTER_EN undefined: filter removed; filtered bit = sync output.
// STRUCTURE
//  ioexp_pkg:
//   - Group base localparams: IOEXP_IN_BASE=8'h00, OUT=8'h08, POL=8'h10, CFG=8'h18, MSK=8'h20.
//   - Group stride 8; NPORT_MAX=8.
//   - FSM state encoding PRIME/RUN.
//  Sub-module ioexp_in_filter:
//   - One bit wide: sync + optional stability counter.
//   - Instantiated NPORT*8 times via generate.
// TESTING
//  T1 reset: nrst pulse ->
//   - oOut=OUT_RST, oOe=~CFG_RST, oInt_n=1 throughout PRIME.
//   - Reads: CFG0=8'hFF, MSK0=8'hFF, off 0x40 -> 8'hFF.
//  T2 change interrupt:
//   - Stimulus: NPORT=2, MSK0=8'hFE, iIntEn=1, iPins[0] 0->1.
//   - oInt_n falls exactly 4 clk later.
//   - Read IN0 -> 8'h01; oInt_n=1 on the next edge; oPending=2'b00.
//  T3 mask:
//   - Stimulus: toggle iPins[9] with MSK1=8'hFF.
//   - oPending[1]=1, oInt_n stays 1.
//   - Write MSK1=8'hFD -> oInt_n=0 next cycle.
//  T4 read/change collision: iPins[3] toggles on the same edge as iRdEn at IN0 ->
//   - pend cleared on that edge.
//   - Re-set one cycle later once the new value reaches val; oInt_n falls again.
//  T5 polarity/output:
//   - Write POL0=8'h0F -> IN0 read = pins^8'h0F; pend0 set.
//   - Write CFG0=8'h00, OUT0=8'hA5 -> oOe[7:0]=8'hFF, oOut[7:0]=8'hA5.
//  T6 filter (IOEXP_INPUT_FILTER_EN, FILTER_CYC=16):
//   - 10-cycle glitch -> no pend.
//   - 20-cycle level -> oInt_n falls at cycle 4+16.
//   - Reset asserted mid-count -> no interrupt after release.

Source files
------------

// File: rtl/ioexp_multiport_ctrl_pkg.sv
// Shared definitions for the multi-port IO-expander register bank.
// Register groups sit at a stride of 8 offsets, one byte per port.
package ioexp_multiport_ctrl_pkg;

   localparam int unsigned NPORT_MAX        = 8;
   localparam int unsigned IOEXP_GRP_STRIDE = 8;

   localparam logic [7:0] IOEXP_IN_BASE  = 8'h00;
   localparam logic [7:0] IOEXP_OUT_BASE = 8'h08;
   localparam logic [7:0] IOEXP_POL_BASE = 8'h10;
   localparam logic [7:0] IOEXP_CFG_BASE = 8'h18;
   localparam logic [7:0] IOEXP_MSK_BASE = 8'h20;

   typedef enum logic {
      ST_PRIME = 1'b0,
      ST_RUN   = 1'b1
   } ioexp_state_e;

   typedef enum logic [2:0] {
      GRP_IN,
      GRP_OUT,
      GRP_POL,
      GRP_CFG,
      GRP_MSK,
      GRP_NONE
   } ioexp_grp_e;

   // Map an offset to its register group; the low bits select the port.
   function automatic ioexp_grp_e grp_decode(input logic [7:0] off);
      logic [7:0] base;
      ioexp_grp_e grp;
      base = off & ~8'(IOEXP_GRP_STRIDE - 1);
      case (base)
         IOEXP_IN_BASE:  grp = GRP_IN;
         IOEXP_OUT_BASE: grp = GRP_OUT;
         IOEXP_POL_BASE: grp = GRP_POL;
         IOEXP_CFG_BASE: grp = GRP_CFG;
         IOEXP_MSK_BASE: grp = GRP_MSK;
         default:        grp = GRP_NONE;
      endcase
      return grp;
   endfunction

endpackage

// File: rtl/ioexp_multiport_ctrl_if.sv
// Byte-level offset/data bus between the SMBus slave and the register bank.
interface ioexp_multiport_ctrl_if;

   logic       iWrEn;
   logic       iRdEn;
   logic [7:0] iOffset;
   logic [7:0] iWrData;
   logic [7:0] oRdData;

   modport master (
      output iWrEn,
      output iRdEn,
      output iOffset,
      output iWrData,
      input  oRdData
   );

   modport slave (
      input  iWrEn,
      input  iRdEn,
      input  iOffset,
      input  iWrData,
      output oRdData
   );

endinterface

// File: rtl/ioexp_multiport_ctrl_in_filter.sv
// One pin of the input path: 2-flop synchroniser, optionally followed by a
// stability filter (macro IOEXP_INPUT_FILTER_EN).
module ioexp_multiport_ctrl_in_filter #(
   parameter int unsigned FILTER_CYC = 16
) (
   input  logic iClk,
   input  logic nrst,
   input  logic pin_i,
   output logic val_o,
   output logic seeded_o
);

   logic sync1_q;
   logic sync2_q;

   // Two-stage synchroniser for the asynchronous pin.
   always_ff @(posedge iClk or negedge nrst) begin
      if (!nrst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= pin_i;
         sync2_q <= sync1_q;
      end
   end

`ifdef IOEXP_INPUT_FILTER_EN
   localparam logic [15:0] CYC_LAST = 16'(FILTER_CYC - 1);

   logic [15:0] cnt_q, cnt_d;
   logic        filt_q, filt_d;
   logic        seeded_q, seeded_d;

   // Until seeded, the counter free-runs once and then loads the pin level;
   // afterwards it counts only while the synced bit differs from the output.
   always_comb begin
      cnt_d    = cnt_q;
      filt_d   = filt_q;
      seeded_d = seeded_q;
      if (!seeded_q) begin
         if (cnt_q == CYC_LAST) begin
            filt_d   = sync2_q;
            seeded_d = 1'b1;
            cnt_d    = '0;
         end else begin
            cnt_d = cnt_q + 16'd1;
         end
      end else if (sync2_q == filt_q) begin
         cnt_d = '0;
      end else if (cnt_q == CYC_LAST) begin
         filt_d = sync2_q;
         cnt_d  = '0;
      end else begin
         cnt_d = cnt_q + 16'd1;
      end
   end

   // Filter state register.
   always_ff @(posedge iClk or negedge nrst) begin
      if (!nrst) begin
         cnt_q    <= '0;
         filt_q   <= 1'b0;
         seeded_q <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         filt_q   <= filt_d;
         seeded_q <= seeded_d;
      end
   end

   assign val_o    = filt_q;
   assign seeded_o = seeded_q;
`else
   assign val_o    = sync2_q;
   assign seeded_o = 1'b1;
`endif

endmodule

// File: rtl/ioexp_multiport_ctrl.sv
// NPORT x 8-bit SMBus IO-expander register bank (IN/OUT/POL/CFG/MSK groups)
// with change-detect pending latches, read-to-clear and a registered
// active-low interrupt. Optional input filter: IOEXP_INPUT_FILTER_EN.
module ioexp_multiport_ctrl
   import ioexp_multiport_ctrl_pkg::*;
#(
   parameter int unsigned        NPORT      = 2,
   parameter logic [NPORT*8-1:0] OUT_RST    = {NPORT{8'hFF}},
   parameter logic [NPORT*8-1:0] CFG_RST    = {NPORT{8'hFF}},
   parameter logic [NPORT*8-1:0] MASK_RST   = {NPORT{8'hFF}},
   parameter int unsigned        FILTER_CYC = 16
) (
   input  logic                 iClk,
   input  logic                 nrst,
   ioexp_multiport_ctrl_if.slave sbus,
   input  logic                 iIntEn,
   input  logic [NPORT*8-1:0]   iPins,
   output logic [NPORT*8-1:0]   oOut,
   output logic [NPORT*8-1:0]   oOe,
   output logic                 oInt_n,
   output logic [NPORT-1:0]     oPending
);

   localparam int unsigned NBIT = NPORT * 8;

   ioexp_state_e state_q, state_d;
   logic [1:0]   prime_cnt_q, prime_cnt_d;

   logic [NBIT-1:0] out_q,  out_d;
   logic [NBIT-1:0] pol_q,  pol_d;
   logic [NBIT-1:0] cfg_q,  cfg_d;
   logic [NBIT-1:0] msk_q,  msk_d;
   logic [NBIT-1:0] pend_q, pend_d;
   logic [NBIT-1:0] snap_q, snap_d;
   logic            int_n_q, int_n_d;

   logic [NBIT-1:0] filt;
   logic [NBIT-1:0] seeded;
   logic [NBIT-1:0] val;
   ioexp_grp_e      grp;
   logic [2:0]      idx;

   for (genvar g = 0; g < NBIT; g++) begin : g_bit
      ioexp_multiport_ctrl_in_filter #(
         .FILTER_CYC(FILTER_CYC)
      ) u_filt (
         .iClk     (iClk),
         .nrst     (nrst),
         .pin_i    (iPins[g]),
         .val_o    (filt[g]),
         .seeded_o (seeded[g])
      );
   end

   assign val = filt ^ pol_q;
   assign grp = grp_decode(sbus.iOffset);
   assign idx = sbus.iOffset[2:0];

   // Combinational read mux; unmapped groups and absent ports read 0xFF.
   always_comb begin
      sbus.oRdData = 8'hFF;
      for (int unsigned p = 0; p < NPORT; p++) begin
         if (idx == 3'(p)) begin
            case (grp)
               GRP_IN:  sbus.oRdData = val[8*p +: 8];
               GRP_OUT: sbus.oRdData = out_q[8*p +: 8];
               GRP_POL: sbus.oRdData = pol_q[8*p +: 8];
               GRP_CFG: sbus.oRdData = cfg_q[8*p +: 8];
               GRP_MSK: sbus.oRdData = msk_q[8*p +: 8];
               default: sbus.oRdData = 8'hFF;
            endcase
         end
      end
   end

   // Priming FSM next state: hold PRIME for 3 cycles and until all filters seeded.
   always_comb begin
      state_d     = state_q;
      prime_cnt_d = prime_cnt_q;
      if (state_q == ST_PRIME) begin
         if (prime_cnt_q != 2'd2) begin
            prime_cnt_d = prime_cnt_q + 2'd1;
         end else if (&seeded) begin
            state_d = ST_RUN;
         end
      end
   end

   // Priming FSM state register.
   always_ff @(posedge iClk or negedge nrst) begin
      if (!nrst) begin
         state_q     <= ST_PRIME;
         prime_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         prime_cnt_q <= prime_cnt_d;
      end
   end

   // Register-bank next state: writes, change detect and read-to-clear.
   // The clear is applied after the set so it wins on a colliding edge.
   always_comb begin
      out_d   = out_q;
      pol_d   = pol_q;
      cfg_d   = cfg_q;
      msk_d   = msk_q;
      pend_d  = pend_q;
      snap_d  = snap_q;
      int_n_d = ~(iIntEn & (|(pend_q & ~msk_q)));

      if (state_q == ST_PRIME) begin
         snap_d = val;
         pend_d = '0;
      end else begin
         pend_d = pend_q | (val ^ snap_q);
         for (int unsigned p = 0; p < NPORT; p++) begin
            if (sbus.iRdEn && (grp == GRP_IN) && (idx == 3'(p))) begin
               snap_d[8*p +: 8] = val[8*p +: 8];
               pend_d[8*p +: 8] = '0;
            end
         end
      end

      for (int unsigned p = 0; p < NPORT; p++) begin
         if (sbus.iWrEn && (idx == 3'(p))) begin
            case (grp)
               GRP_OUT: out_d[8*p +: 8] = sbus.iWrData;
               GRP_POL: pol_d[8*p +: 8] = sbus.iWrData;
               GRP_CFG: cfg_d[8*p +: 8] = sbus.iWrData;
               GRP_MSK: msk_d[8*p +: 8] = sbus.iWrData;
               default: ;
            endcase
         end
      end
   end

   // Register-bank state.
   always_ff @(posedge iClk or negedge nrst) begin
      if (!nrst) begin
         out_q   <= OUT_RST;
         pol_q   <= '0;
         cfg_q   <= CFG_RST;
         msk_q   <= MASK_RST;
         pend_q  <= '0;
         snap_q  <= '0;
         int_n_q <= 1'b1;
      end else begin
         out_q   <= out_d;
         pol_q   <= pol_d;
         cfg_q   <= cfg_d;
         msk_q   <= msk_d;
         pend_q  <= pend_d;
         snap_q  <= snap_d;
         int_n_q <= int_n_d;
      end
   end

   // Per-port pending summary, independent of the mask.
   always_comb begin
      oPending = '0;
      for (int unsigned p = 0; p < NPORT; p++) begin
         oPending[p] = |pend_q[8*p +: 8];
      end
   end

   assign oOut   = out_q;
   assign oOe    = ~cfg_q;
   assign oInt_n = int_n_q;

endmodule

// File: tb/tb_ioexp_multiport_ctrl.sv
// Self-checking bench for ioexp_multiport_ctrl (default build, NPORT=2):
// directed scenarios followed by randomized traffic against a register-level model.
module tb_ioexp_multiport_ctrl;

   localparam int NP = 2;

   logic            clk = 1'b0;
   logic            nrst = 1'b0;
   logic            inten = 1'b0;
   logic [NP*8-1:0] pins = '0;
   logic [NP*8-1:0] oOut;
   logic [NP*8-1:0] oOe;
   logic            oInt_n;
   logic [NP-1:0]   oPending;

   int n_tests = 0;
   int n_fail  = 0;

   ioexp_multiport_ctrl_if bus ();

   ioexp_multiport_ctrl #(
      .NPORT(NP)
   ) dut (
      .iClk     (clk),
      .nrst     (nrst),
      .sbus     (bus),
      .iIntEn   (inten),
      .iPins    (pins),
      .oOut     (oOut),
      .oOe      (oOe),
      .oInt_n   (oInt_n),
      .oPending (oPending)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   logic [7:0]      m_out  [NP];
   logic [7:0]      m_pol  [NP];
   logic [7:0]      m_cfg  [NP];
   logic [7:0]      m_msk  [NP];
   logic [7:0]      m_pend [NP];
   logic [7:0]      m_snap [NP];
   logic [NP*8-1:0] m_p1, m_p2;   // pin samples one and two edges old
   logic            m_int_n;
   int              m_cyc;        // edges since reset release

   function automatic logic [7:0] m_val(int q);
      return m_p2[8*q +: 8] ^ m_pol[q];
   endfunction

   function automatic logic [7:0] m_read(logic [7:0] off);
      int g, p;
      g = int'(off) / 8;
      p = int'(off) % 8;
      if (p >= NP) return 8'hFF;
      case (g)
         0: return m_val(p);
         1: return m_out[p];
         2: return m_pol[p];
         3: return m_cfg[p];
         4: return m_msk[p];
         default: return 8'hFF;
      endcase
   endfunction

   task automatic m_reset();
      for (int q = 0; q < NP; q++) begin
         m_out[q] = 8'hFF; m_cfg[q] = 8'hFF; m_msk[q] = 8'hFF;
         m_pol[q] = 8'h00; m_pend[q] = 8'h00; m_snap[q] = 8'h00;
      end
      m_p1 = '0; m_p2 = '0; m_int_n = 1'b1; m_cyc = 0;
   endtask

   // Model effect of one clock edge, using the inputs presented before it.
   task automatic m_edge();
      logic any;
      int g, p;
      logic [7:0] v;
      any = 1'b0;
      for (int q = 0; q < NP; q++)
         if ((m_pend[q] & ~m_msk[q]) != 8'h00) any = 1'b1;
      g = int'(bus.iOffset) / 8;
      p = int'(bus.iOffset) % 8;
      for (int q = 0; q < NP; q++) begin
         v = m_val(q);
         if (m_cyc < 3) begin
            m_snap[q] = v;
            m_pend[q] = 8'h00;
         end else begin
            m_pend[q] = m_pend[q] | (v ^ m_snap[q]);
            if (bus.iRdEn && g == 0 && q == p) begin
               m_snap[q] = v;
               m_pend[q] = 8'h00;
            end
         end
      end
      if (bus.iWrEn && p < NP) begin
         case (g)
            1: m_out[p] = bus.iWrData;
            2: m_pol[p] = bus.iWrData;
            3: m_cfg[p] = bus.iWrData;
            4: m_msk[p] = bus.iWrData;
            default: ;
         endcase
      end
      m_int_n = !(inten && any);
      m_p2 = m_p1;
      m_p1 = pins;
      m_cyc++;
   endtask

   // ---------------- checking helpers ----------------
   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      n_tests++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      m_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic check_state(string tag);
      logic [NP*8-1:0] eo, eoe;
      logic [NP-1:0]   ep;
      for (int q = 0; q < NP; q++) begin
         eo[8*q +: 8]  = m_out[q];
         eoe[8*q +: 8] = ~m_cfg[q];
         ep[q]         = |m_pend[q];
      end
      chk({tag, ".int_n"}, 32'(oInt_n), 32'(m_int_n));
      chk({tag, ".pend"},  32'(oPending), 32'(ep));
      chk({tag, ".out"},   32'(oOut), 32'(eo));
      chk({tag, ".oe"},    32'(oOe), 32'(eoe));
   endtask

   task automatic check_read(string tag, logic [7:0] off);
      bus.iOffset = off;
      #1;
      chk(tag, 32'(bus.oRdData), 32'(m_read(off)));
   endtask

   task automatic do_write(logic [7:0] off, logic [7:0] d);
      bus.iWrEn = 1'b1; bus.iOffset = off; bus.iWrData = d;
      tick();
      bus.iWrEn = 1'b0;
   endtask

   task automatic do_read(logic [7:0] off);
      bus.iRdEn = 1'b1; bus.iOffset = off;
      tick();
      bus.iRdEn = 1'b0;
   endtask

   task automatic do_reset();
      nrst = 1'b0;
      m_reset();
      @(posedge clk);
      #1;
      nrst = 1'b1;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [7:0] off, wd;
      int r;
      bus.iWrEn = 1'b0; bus.iRdEn = 1'b0; bus.iOffset = '0; bus.iWrData = '0;
      m_reset();
      #3;

      // T1: reset state and priming window
      do_reset();
      chk("t1.out_rst", 32'(oOut), 32'hFFFF);
      chk("t1.oe_rst", 32'(oOe), 32'h0000);
      check_state("t1.rst");
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("t1.prime_int", 32'(oInt_n), 32'h1);
      end
      bus.iOffset = 8'h18; #1; chk("t1.cfg0", 32'(bus.oRdData), 32'hFF);
      bus.iOffset = 8'h20; #1; chk("t1.msk0", 32'(bus.oRdData), 32'hFF);
      bus.iOffset = 8'h40; #1; chk("t1.unmapped", 32'(bus.oRdData), 32'hFF);
      bus.iOffset = 8'h02; #1; chk("t1.noport", 32'(bus.oRdData), 32'hFF);
      tick();

      // T2: change interrupt, exact latency, read-to-clear
      do_write(8'h20, 8'hFE);
      inten = 1'b1;
      tick();
      pins[0] = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         tick();
         chk("t2.int_early", 32'(oInt_n), 32'h1);
      end
      tick();
      chk("t2.int_fall", 32'(oInt_n), 32'h0);
      check_state("t2.model");
      bus.iOffset = 8'h00; #1; chk("t2.in0", 32'(bus.oRdData), 32'h01);
      do_read(8'h00);
      chk("t2.pend_clr", 32'(oPending), 32'h0);
      tick();
      chk("t2.int_rel", 32'(oInt_n), 32'h1);

      // T3: masked change still latches pending; unmask asserts
      pins[9] = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      chk("t3.pend1", 32'(oPending), 32'h2);
      chk("t3.int_masked", 32'(oInt_n), 32'h1);
      do_write(8'h21, 8'hFD);
      tick();
      chk("t3.int_unmask", 32'(oInt_n), 32'h0);
      do_write(8'h21, 8'hFF);
      tick();
      chk("t3.int_remask", 32'(oInt_n), 32'h1);
      chk("t3.pend_kept", 32'(oPending), 32'h2);
      do_read(8'h01);
      tick();
      check_state("t3.model");

      // T4: read-clear on the same edge as a pin change
      do_write(8'h20, 8'h00);
      tick();
      pins[3] = 1'b1;
      do_read(8'h00);
      chk("t4.clr", 32'(oPending), 32'h0);
      tick();
      chk("t4.clr_hold", 32'(oPending), 32'h0);
      tick();
      chk("t4.reset_pend", 32'(oPending), 32'h1);
      tick();
      chk("t4.int_again", 32'(oInt_n), 32'h0);
      check_state("t4.model");

      // T5: polarity and output/config
      do_read(8'h00);
      tick();
      do_write(8'h10, 8'h0F);
      bus.iOffset = 8'h00; #1;
      chk("t5.pol_in", 32'(bus.oRdData), 32'(pins[7:0] ^ 8'h0F));
      tick();
      chk("t5.pol_pend", 32'(oPending[0]), 32'h1);
      do_write(8'h18, 8'h00);
      do_write(8'h08, 8'hA5);
      chk("t5.oe", 32'(oOe[7:0]), 32'hFF);
      chk("t5.out", 32'(oOut[7:0]), 32'hA5);
      check_state("t5.model");

      // Randomized traffic against the model
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 3) == 0) pins = pins ^ (16'(1) << $urandom_range(0, 15));
         if ($urandom_range(0, 15) == 0) inten = ~inten;
         r = $urandom_range(0, 9);
         wd = 8'($urandom);
         if (r < 3 || r == 9) off = 8'($urandom_range(0, 5) * 8 + $urandom_range(0, 2));
         else off = 8'($urandom_range(0, 2));
         bus.iWrEn = (r < 3) || (r == 9);
         bus.iRdEn = (r >= 3 && r < 6) || (r == 9);
         bus.iOffset = off;
         bus.iWrData = wd;
         tick();
         bus.iWrEn = 1'b0;
         bus.iRdEn = 1'b0;
         check_state("rnd");
         check_read("rnd.rd", 8'($urandom_range(0, 8'h2F)));
      end

      // Reset asserted mid-cycle returns everything to reset values at once
      do_write(8'h09, 8'h3C);
      #2;
      nrst = 1'b0;
      #1;
      chk("rst.out", 32'(oOut), 32'hFFFF);
      chk("rst.oe", 32'(oOe), 32'h0000);
      chk("rst.int_n", 32'(oInt_n), 32'h1);
      chk("rst.pend", 32'(oPending), 32'h0);
      m_reset();
      @(posedge clk);
      #1;
      nrst = 1'b1;
      for (int i = 0; i < 6; i++) tick();
      check_state("rst.after");
      check_read("rst.rd_out1", 8'h09);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
